// File: rtl/wb_dma.sv
// wb_dma: single-channel Wishbone memory-to-memory copy engine.
// A responder port holds the SRC/DST/LEN/CTRL registers; an initiator port
// moves one word at a time as a read beat followed by a write beat, with one
// idle cycle after each beat so the upstream arbiter can re-evaluate.
module wb_dma #(
  parameter int LenWidth = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  // responder port
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  output logic        wb_ack,
  output logic        wb_err,
  // initiator port
  output logic        wbm_cyc,
  output logic        wbm_stb,
  output logic        wbm_we,
  output logic [3:0]  wbm_sel,
  output logic [31:0] wbm_addr,
  output logic [31:0] wbm_wdata,
  input  logic [31:0] wbm_rdata,
  input  logic        wbm_ack,
  input  logic        wbm_err,
  output logic        irq_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR     = 3'd3,
    S_WR_GAP = 3'd4
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam logic [LenWidth-1:0] LEN_ONE = LenWidth'(1);

  state_t              state, next_state;
  logic [31:0]         src, dst;
  logic [LenWidth-1:0] len;
  logic [31:0]         data_q;
  logic                ie, done, err, abort_q;
  logic                busy;

  // responder decode
  logic        acc, wr_en, ctrl_wr, start_req, abort_wr;
  logic [1:0]  reg_sel;
  logic [31:0] rd_mux, rd_len;

  // FSM side effects
  logic bus_cyc, bus_we, capture, step, set_err, set_done;
  logic [31:0] bus_addr, bus_wdata;

  // Byte lanes and undecoded address bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{wb_sel, wb_addr[31:4], wb_addr[1:0]};

  assign busy      = (state != S_IDLE);
  assign reg_sel   = wb_addr[3:2];
  // A new access is taken only when the previous one is not being acked,
  // which limits the responder to one access per two cycles.
  assign acc       = wb_cyc & wb_stb & ~wb_ack;
  assign wr_en     = acc & wb_we;
  assign ctrl_wr   = wr_en & (reg_sel == REG_CTRL);
  // ABORT in the same write suppresses START.
  assign start_req = ctrl_wr & wb_wdata[0] & ~wb_wdata[2];
  assign abort_wr  = ctrl_wr & wb_wdata[2];

  assign wb_err  = 1'b0;
  assign irq_out = done & ie;

  assign wbm_cyc   = bus_cyc;
  assign wbm_stb   = bus_cyc;
  assign wbm_we    = bus_we;
  assign wbm_sel   = bus_cyc ? 4'hF : 4'h0;
  assign wbm_addr  = bus_addr;
  assign wbm_wdata = bus_wdata;

  // FSM state register; async reset drops the initiator strobe immediately.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= S_IDLE;
    else           state <= next_state;
  end

  // FSM next state, bus outputs and register-update strobes.
  always_comb begin
    next_state = state;
    bus_cyc    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = 32'h0;
    bus_wdata  = 32'h0;
    capture    = 1'b0;
    step       = 1'b0;
    set_err    = 1'b0;
    set_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          if (len != '0) next_state = S_RD;
          else           set_done   = 1'b1;
        end
      end
      S_RD: begin
        bus_cyc  = 1'b1;
        bus_addr = src;
        // err has priority over a simultaneous ack
        if (wbm_err) begin
          set_err    = 1'b1;
          next_state = S_IDLE;
        end else if (wbm_ack) begin
          capture    = 1'b1;
          next_state = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        next_state = abort_q ? S_IDLE : S_WR;
      end
      S_WR: begin
        bus_cyc   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = dst;
        bus_wdata = data_q;
        if (wbm_err) begin
          set_err    = 1'b1;
          next_state = S_IDLE;
        end else if (wbm_ack) begin
          step       = 1'b1;
          next_state = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        // len already reflects the word just written
        if (abort_q) begin
          next_state = S_IDLE;
        end else if (len == '0) begin
          set_done   = 1'b1;
          next_state = S_IDLE;
        end else begin
          next_state = S_RD;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Pending abort: honoured at the next gap state, dropped whenever we go idle.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)                 abort_q <= 1'b0;
    else if (next_state == S_IDLE) abort_q <= 1'b0;
    else if (abort_wr && busy)     abort_q <= 1'b1;
  end

  // Word in flight between the read and the write beat.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)    data_q <= 32'h0;
    else if (capture) data_q <= wbm_rdata;
  end

  // Programming registers, live progress counters and sticky status.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      src  <= 32'h0;
      dst  <= 32'h0;
      len  <= '0;
      ie   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      // address/count writes are dropped while a copy is running
      if (wr_en && !busy) begin
        case (reg_sel)
          REG_SRC: src <= {wb_wdata[31:2], 2'b00};
          REG_DST: dst <= {wb_wdata[31:2], 2'b00};
          REG_LEN: len <= wb_wdata[LenWidth-1:0];
          default: ;
        endcase
      end
      if (step) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len - LEN_ONE;
      end
      // W1C clears first so a START in the same write can set DONE again
      if (ctrl_wr) begin
        ie <= wb_wdata[1];
        if (wb_wdata[8]) done <= 1'b0;
        if (wb_wdata[9]) err  <= 1'b0;
      end
      if (set_done) done <= 1'b1;
      if (set_err)  err  <= 1'b1;
    end
  end

  // Register read mux; LEN is zero-extended.
  always_comb begin
    rd_len                 = 32'h0;
    rd_len[LenWidth-1:0]   = len;
    case (reg_sel)
      REG_SRC: rd_mux = src;
      REG_DST: rd_mux = dst;
      REG_LEN: rd_mux = rd_len;
      default: rd_mux = {22'h0, err, done, 6'h0, ie, busy};
    endcase
  end

  // Responder handshake: ack exactly one cycle after the access, data with it.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wb_ack   <= 1'b0;
      wb_rdata <= 32'h0;
    end else begin
      wb_ack <= acc;
      if (acc) wb_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_wb_dma.sv
// Directed bench for wb_dma: registered-ack memory model with programmable
// wait states and error injection, plus a strobe-hold monitor.
module tb_wb_dma;

  logic        clk_in   = 1'b0;
  logic        reset_in = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'hF;
  logic [31:0] wb_addr = 32'h0, wb_wdata = 32'h0;
  logic [31:0] wb_rdata;
  logic        wb_ack, wb_err;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_addr, wbm_wdata, wbm_rdata;
  logic        wbm_ack = 1'b0, wbm_err = 1'b0;
  logic        irq_out;

  localparam logic [31:0] A_SRC = 32'h0, A_DST = 32'h4, A_LEN = 32'h8, A_CTRL = 32'hC;

  int checks = 0;
  int errors = 0;

  wb_dma #(.LenWidth(16)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we), .wbm_sel(wbm_sel),
    .wbm_addr(wbm_addr), .wbm_wdata(wbm_wdata), .wbm_rdata(wbm_rdata),
    .wbm_ack(wbm_ack), .wbm_err(wbm_err), .irq_out(irq_out)
  );

  always #5 clk_in = ~clk_in;

  // memory contents are a fixed function of the address
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign wbm_rdata = (wbm_cyc && !wbm_we) ? pat(wbm_addr) : 32'h0;

  // memory model: ack (or err) after mem_delay extra wait cycles, logs beats
  int          mem_delay = 0;
  int          err_at    = -1;
  int          beat_cnt  = 0;
  int          wcnt      = 0;
  logic [31:0] log_addr [0:255];
  logic [31:0] log_data [0:255];
  logic        log_we   [0:255];

  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wbm_ack <= 1'b0;
      wbm_err <= 1'b0;
      wcnt    <= 0;
    end else if (wbm_ack || wbm_err) begin
      wbm_ack <= 1'b0;
      wbm_err <= 1'b0;
      wcnt    <= 0;
    end else if (wbm_cyc && wbm_stb) begin
      if (wcnt >= mem_delay) begin
        if (beat_cnt == err_at) wbm_err <= 1'b1;
        else                    wbm_ack <= 1'b1;
        log_addr[beat_cnt[7:0]] <= wbm_addr;
        log_data[beat_cnt[7:0]] <= wbm_wdata;
        log_we[beat_cnt[7:0]]   <= wbm_we;
        beat_cnt <= beat_cnt + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // initiator must hold stb/addr/we/wdata/sel until ack or err
  logic        hold_pend = 1'b0, hold_we = 1'b0;
  logic [31:0] hold_addr = 32'h0, hold_wdata = 32'h0;
  int          hold_viol  = 0;
  int          stb_cycles = 0;

  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      hold_pend <= 1'b0;
    end else begin
      if (wbm_stb) stb_cycles <= stb_cycles + 1;
      if (hold_pend && (!wbm_stb || wbm_addr != hold_addr || wbm_we != hold_we ||
                        wbm_wdata != hold_wdata || wbm_sel != 4'hF))
        hold_viol <= hold_viol + 1;
      hold_pend  <= wbm_stb && !wbm_ack && !wbm_err;
      hold_addr  <= wbm_addr;
      hold_we    <= wbm_we;
      hold_wdata <= wbm_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk_in); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
    @(posedge clk_in); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk_in); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
    @(posedge clk_in); #1;
    d = wb_rdata;
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    wb_read(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    int b0;
    int cyc;
    int s0;
    logic [31:0] v;

    // ---- reset ----
    #2 reset_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_wbm_cyc", {31'h0, wbm_cyc}, 32'h0);
    check("rst_wbm_sel", {28'h0, wbm_sel}, 32'h0);
    check("rst_wbm_addr", wbm_addr, 32'h0);
    check("rst_irq", {31'h0, irq_out}, 32'h0);
    reset_in = 1'b1;
    check_reg("rst_src", A_SRC, 32'h0);
    check_reg("rst_dst", A_DST, 32'h0);
    check_reg("rst_len", A_LEN, 32'h0);
    check_reg("rst_status", A_CTRL, 32'h0);
    check("wb_err_tied", {31'h0, wb_err}, 32'h0);

    // ---- 4-word copy with registered-ack memory ----
    mem_delay = 0;
    wb_write(A_SRC, 32'h3000);
    wb_write(A_DST, 32'h3100);
    wb_write(A_LEN, 32'd4);
    b0 = beat_cnt;
    wb_write(A_CTRL, 32'h3);                 // START | IE
    check("first_stb", {31'h0, wbm_stb}, 32'h1);
    cyc = 0;
    while (!irq_out && cyc < 200) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    check("copy_cycles", cyc, 32'd24);
    check("copy_beats", beat_cnt - b0, 32'd8);
    for (int i = 0; i < 4; i++) begin
      check("rd_we",   {31'h0, log_we[b0+2*i]},  32'h0);
      check("rd_addr", log_addr[b0+2*i],         32'h3000 + 4*i);
      check("wr_we",   {31'h0, log_we[b0+2*i+1]}, 32'h1);
      check("wr_addr", log_addr[b0+2*i+1],       32'h3100 + 4*i);
      check("wr_data", log_data[b0+2*i+1],       pat(32'h3000 + 4*i));
    end
    check_reg("copy_src", A_SRC, 32'h3010);
    check_reg("copy_dst", A_DST, 32'h3110);
    check_reg("copy_len", A_LEN, 32'h0);
    check_reg("copy_status", A_CTRL, 32'h102);
    check("copy_irq", {31'h0, irq_out}, 32'h1);

    // ---- START with LEN=0 ----
    wb_write(A_CTRL, 32'h300);               // clear DONE/ERR, IE=0
    check("clr_irq", {31'h0, irq_out}, 32'h0);
    s0 = stb_cycles;
    wb_write(A_CTRL, 32'h3);                 // START | IE, LEN still 0
    check("len0_irq_next", {31'h0, irq_out}, 32'h1);
    check("len0_no_stb_now", {31'h0, wbm_stb}, 32'h0);
    check_reg("len0_status", A_CTRL, 32'h102);
    check("len0_stb_cycles", stb_cycles - s0, 32'h0);

    // ---- bus error on 2nd read of 3-word copy ----
    wb_write(A_CTRL, 32'h300);
    wb_write(A_SRC, 32'h3000);
    wb_write(A_DST, 32'h3100);
    wb_write(A_LEN, 32'd3);
    b0 = beat_cnt;
    err_at = b0 + 2;
    wb_write(A_CTRL, 32'h1);
    repeat (30) @(posedge clk_in);
    #1;
    err_at = -1;
    check("err_beats", beat_cnt - b0, 32'd3);
    check_reg("err_status", A_CTRL, 32'h200);
    check_reg("err_len", A_LEN, 32'd2);
    check_reg("err_src", A_SRC, 32'h3004);
    check_reg("err_dst", A_DST, 32'h3104);
    wb_write(A_CTRL, 32'h200);
    check_reg("err_w1c", A_CTRL, 32'h0);

    // ---- ABORT during 2nd write's wait states ----
    mem_delay = 5;
    wb_write(A_SRC, 32'h3000);
    wb_write(A_DST, 32'h3100);
    wb_write(A_LEN, 32'd3);
    b0 = beat_cnt;
    wb_write(A_CTRL, 32'h1);
    cyc = 0;
    while (!(beat_cnt - b0 == 3 && wbm_stb && wbm_we) && cyc < 200) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    check("abort_reach_wr2", {31'h0, cyc < 200}, 32'h1);
    wb_write(A_CTRL, 32'h4);                 // ABORT
    check("abort_stb_held", {31'h0, wbm_stb}, 32'h1);
    repeat (40) @(posedge clk_in);
    #1;
    check("abort_beats", beat_cnt - b0, 32'd4);
    check_reg("abort_len", A_LEN, 32'd1);
    check_reg("abort_src", A_SRC, 32'h3008);
    check_reg("abort_status", A_CTRL, 32'h0);

    // ---- address wrap, alignment, LEN write while busy ----
    mem_delay = 0;
    wb_write(A_SRC, 32'h3003);
    check_reg("src_align", A_SRC, 32'h3000);
    wb_write(A_SRC, 32'hFFFF_FFFC);
    wb_write(A_DST, 32'h3100);
    wb_write(A_LEN, 32'd2);
    b0 = beat_cnt;
    wb_write(A_CTRL, 32'h1);
    wb_write(A_LEN, 32'd7);                  // ignored while busy
    repeat (30) @(posedge clk_in);
    #1;
    check("wrap_beats", beat_cnt - b0, 32'd4);
    check("wrap_rd1", log_addr[b0], 32'hFFFF_FFFC);
    check("wrap_rd2", log_addr[b0+2], 32'h0);
    check("wrap_wd2", log_data[b0+3], pat(32'h0));
    check_reg("wrap_len", A_LEN, 32'h0);
    check_reg("wrap_src", A_SRC, 32'h4);
    check_reg("wrap_dst", A_DST, 32'h3108);
    check_reg("wrap_status", A_CTRL, 32'h100);

    // ---- reset mid-RD ----
    wb_write(A_CTRL, 32'h302);               // clear, IE=1
    mem_delay = 5;
    wb_write(A_SRC, 32'h3000);
    wb_write(A_LEN, 32'd3);
    wb_write(A_CTRL, 32'h3);
    cyc = 0;
    while (!wbm_stb && cyc < 20) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    check("rstmid_in_rd", {31'h0, wbm_stb}, 32'h1);
    #3 reset_in = 1'b0;
    #1;
    check("rstmid_cyc", {31'h0, wbm_cyc}, 32'h0);
    check("rstmid_stb", {31'h0, wbm_stb}, 32'h0);
    check("rstmid_addr", wbm_addr, 32'h0);
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b1;
    mem_delay = 0;
    check_reg("rstmid_src", A_SRC, 32'h0);
    check_reg("rstmid_dst", A_DST, 32'h0);
    check_reg("rstmid_len", A_LEN, 32'h0);
    check_reg("rstmid_status", A_CTRL, 32'h0);

    check("stb_hold_viol", hold_viol, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
